// File: rtl/divider_seq.sv
// divider_seq: sequential restoring shift-subtract divider, one quotient bit per clock.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   data_in_a    dividend, captured when Start is accepted in IDLE
//   data_in_b    divisor, captured when Start is accepted in IDLE
//   Start        begin a division (honoured only in IDLE)
//   Reset_Sync   synchronous active-high clear, same effect as reset
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered, set when the captured divisor was 0
//   ready        high only in IDLE
//   done         one-cycle pulse in DONE
//
// Optional feature: define DIVIDER_SIGNED_EN for two's complement operands
// (quotient truncates toward zero, remainder takes the dividend's sign).
module divider_seq #(
    parameter int WORD_LENGTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_LENGTH-1:0] data_in_a,
    input  logic [WORD_LENGTH-1:0] data_in_b,
    input  logic                   Start,
    input  logic                   Reset_Sync,
    output logic [WORD_LENGTH-1:0] quotient,
    output logic [WORD_LENGTH-1:0] remainder,
    output logic                   div_by_zero,
    output logic                   ready,
    output logic                   done
);
    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_d;
    logic [W-1:0]  r_r;
    logic [CW-1:0] r_cnt;

    logic [W:0]    w_shift;
    logic          w_ok;
    logic [W-1:0]  w_diff;
    logic [W-1:0]  w_r_next;
    logic [W-1:0]  w_a_next;
    logic [W-1:0]  w_mag_a;
    logic [W-1:0]  w_mag_b;
    logic [W-1:0]  w_quo;
    logic [W-1:0]  w_rem;

    // The stored remainder is always below the divisor (or equals the
    // consumed dividend bits when dividing by 0), so W bits suffice; only
    // the shifted trial value needs the extra bit.
    assign w_shift  = {r_r, r_a[W-1]};
    assign w_ok     = w_shift >= {1'b0, r_d};
    assign w_diff   = w_shift[W-1:0] - r_d;
    assign w_r_next = w_ok ? w_diff : w_shift[W-1:0];
    assign w_a_next = {r_a[W-2:0], w_ok};

`ifdef DIVIDER_SIGNED_EN
    logic r_sq;
    logic r_sr;

    assign w_mag_a = data_in_a[W-1] ? -data_in_a : data_in_a;
    assign w_mag_b = data_in_b[W-1] ? -data_in_b : data_in_b;
    // Divide-by-zero keeps the raw all-ones quotient; negating |A| restores A.
    assign w_quo   = (r_sq && r_d != '0) ? -w_a_next : w_a_next;
    assign w_rem   = r_sr ? -w_r_next : w_r_next;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_sq <= 1'b0;
            r_sr <= 1'b0;
        end else if (Reset_Sync) begin
            r_sq <= 1'b0;
            r_sr <= 1'b0;
        end else if (r_state == IDLE && Start) begin
            r_sq <= data_in_a[W-1] ^ data_in_b[W-1];
            r_sr <= data_in_a[W-1];
        end
`else
    assign w_mag_a = data_in_a;
    assign w_mag_b = data_in_b;
    assign w_quo   = w_a_next;
    assign w_rem   = w_r_next;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            ready       <= 1'b1;
            done        <= 1'b0;
        end else if (Reset_Sync) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            ready       <= 1'b1;
            done        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (Start) begin
                    r_a     <= w_mag_a;
                    r_d     <= w_mag_b;
                    r_r     <= '0;
                    r_cnt   <= '0;
                    r_state <= BUSY;
                    ready   <= 1'b0;
                end
                BUSY: begin
                    r_a   <= w_a_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(W - 1)) begin
                        r_state     <= DONE;
                        done        <= 1'b1;
                        quotient    <= w_quo;
                        remainder   <= w_rem;
                        div_by_zero <= (r_d == '0);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                end
            endcase
        end
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: directed and random self-checking bench for divider_seq.
module tb_divider_seq;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] data_in_a = '0;
    logic [W-1:0] data_in_b = '0;
    logic         Start = 1'b0;
    logic         Reset_Sync = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         ready;
    logic         done;

    int checks = 0;
    int errors = 0;

    divider_seq #(.WORD_LENGTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .data_in_a(data_in_a),
        .data_in_b(data_in_b),
        .Start(Start),
        .Reset_Sync(Reset_Sync),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .ready(ready),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division on the operand interpretation.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
`ifdef DIVIDER_SIGNED_EN
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        z = (b == '0);
        q = z ? '1 : W'(sa / sb);
        r = z ? a : W'(sa % sb);
`else
        z = (b == '0);
        q = z ? '1 : a / b;
        r = z ? a : a % b;
`endif
    endfunction

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        model(a, b, eq, er, ez);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_ready_done"}, 32'(ready), 32'd0);
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_dz"}, 32'(div_by_zero), 32'(ez));
    endtask

    // Called just after an edge; returns just after the edge that re-enters IDLE.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        data_in_a = a;
        data_in_b = b;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        data_in_a = ~a;
        data_in_b = ~b;
        chk({tag, "_ready_busy"}, 32'(ready), 32'd0);
        repeat (W - 1) @(posedge clk);
        #1;
        chk({tag, "_done_early"}, 32'(done), 32'd0);
        @(posedge clk); #1;
        check_result(tag, a, b);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dz", 32'(div_by_zero), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_div("d13_3", 4'd13, 4'd3);
        run_div("d7_0", 4'd7, 4'd0);

        // Start held: second capture happens on the first IDLE edge.
        data_in_a = 4'd15;
        data_in_b = 4'd1;
        Start = 1'b1;
        @(posedge clk); #1;
        data_in_a = 4'd5;
        data_in_b = 4'd7;
        repeat (W) @(posedge clk);
        #1;
        check_result("b2b1", 4'd15, 4'd1);
        @(posedge clk); #1;
        chk("b2b_ready_idle", 32'(ready), 32'd1);
        @(posedge clk); #1;
        chk("b2b_ready_cap2", 32'(ready), 32'd0);
        Start = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        check_result("b2b2", 4'd5, 4'd7);
        @(posedge clk); #1;

        // Retrigger at k+2 is ignored.
        data_in_a = 4'd9;
        data_in_b = 4'd2;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        @(posedge clk); #1;
        data_in_a = 4'd1;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (W - 2) @(posedge clk);
        #1;
        check_result("retrig", 4'd9, 4'd2);
        @(posedge clk); #1;

        // Reset_Sync mid-division.
        data_in_a = 4'd14;
        data_in_b = 4'd3;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        @(posedge clk); #1;
        Reset_Sync = 1'b1;
        @(posedge clk); #1;
        Reset_Sync = 1'b0;
        chk("rs_ready", 32'(ready), 32'd1);
        chk("rs_q", 32'(quotient), 32'd0);
        chk("rs_r", 32'(remainder), 32'd0);
        chk("rs_dz", 32'(div_by_zero), 32'd0);
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            chk("rs_no_done", 32'(done), 32'd0);
        end

        // Async reset mid-cycle during a division.
        run_div("pre_async", 4'd11, 4'd0);
        data_in_a = 4'd14;
        data_in_b = 4'd3;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("ar_ready", 32'(ready), 32'd1);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_q", 32'(quotient), 32'd0);
        chk("ar_r", 32'(remainder), 32'd0);
        chk("ar_dz", 32'(div_by_zero), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ar_idle", 32'(ready), 32'd1);

`ifdef DIVIDER_SIGNED_EN
        run_div("s_m7_2", 4'b1001, 4'd2);
        chk("s_m7_2_qc", 32'(quotient), 32'hD);
        chk("s_m7_2_rc", 32'(remainder), 32'hF);
        run_div("s_m8_m1", 4'b1000, 4'b1111);
        chk("s_m8_m1_qc", 32'(quotient), 32'h8);
        chk("s_m8_m1_rc", 32'(remainder), 32'h0);
`endif

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = (i % 6 == 0) ? '0 : W'($urandom_range(0, 15));
            run_div("rand", ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
